// File: rtl/addsub_checker_pkg.sv
// Shared constants for the add/sub result checker.
// Holds the FSM encoding, the default operand width and the error counter limits.
package addsub_checker_pkg;

  localparam int N_DEF = 4;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t CALC   = 2'd1;
  localparam state_t REPORT = 2'd2;

endpackage

// File: rtl/addsub_inverse.sv
// Undoes the add/sub operation to recover operand A from ans and b.
// Everything is done at N+1 bits so the recovery never wraps.
module addsub_inverse
  import addsub_checker_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   ans,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N:0]   r
);

  logic [N:0] bx;

  assign bx = {b[N-1], b};
  assign r  = sel ? (ans - bx) : (ans + bx);

endmodule

// File: rtl/addsub_checker.sv
// Captures an (a, b, sel, ans) tuple, verifies ans by inverse arithmetic,
// and reports pass/overflow with a saturating count of failures.
module addsub_checker
  import addsub_checker_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             sel,
  input  logic [N:0]       ans,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pass,
  output logic [N-1:0]     recovered_a,
  output logic             overflow,
  output logic [ERR_W-1:0] err_count
);

  state_t state_q, state_d;

  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             sel_q, sel_d;
  logic [N:0]       ans_q, ans_d;
  logic             pass_q, pass_d;
  logic [N-1:0]     reca_q, reca_d;
  logic             ovf_q, ovf_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N:0]       r;

  addsub_inverse #(.N(N)) u_inv (
    .ans (ans_q),
    .b   (b_q),
    .sel (sel_q),
    .r   (r)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    ans_d   = ans_q;
    pass_d  = pass_q;
    reca_d  = reca_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          ans_d   = ans;
          state_d = CALC;
        end
      end
      (state_q == CALC): begin
        pass_d  = (r == {a_q[N-1], a_q});
        reca_d  = r[N-1:0];
        ovf_d   = ans_q[N] ^ ans_q[N-1];
        state_d = REPORT;
      end
      (state_q == REPORT): begin
        if (out_ready) begin
          state_d = IDLE;
          if (!pass_q && (err_q != ERR_MAX))
            err_d = err_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      ans_q   <= '0;
      pass_q  <= 1'b0;
      reca_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      ans_q   <= ans_d;
      pass_q  <= pass_d;
      reca_q  <= reca_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == REPORT);
  assign pass        = pass_q;
  assign recovered_a = reca_q;
  assign overflow    = ovf_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_addsub_checker.sv
// Scoreboard bench for addsub_checker (N=4): driver pushes expected
// verdicts, a negedge monitor pops and compares on each handshake.
module tb_addsub_checker;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         sel = 1'b0;
  logic [N:0]   ans = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         pass;
  logic [N-1:0] recovered_a;
  logic         overflow;
  logic [7:0]   err_count;

  addsub_checker #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sel         (sel),
    .ans         (ans),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pass        (pass),
    .recovered_a (recovered_a),
    .overflow    (overflow),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pass;
    logic [3:0] reca;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   model_err = 0;
  int   rdy_mode = 0;
  logic rdy_hold = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: recover a with plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] ai, input logic [3:0] bi,
                                 input logic si, input logic [4:0] ansi);
    exp_t e;
    int av, bv, nv, rv;
    av = $signed(ai);
    bv = $signed(bi);
    nv = $signed(ansi);
    rv = si ? (nv - bv) : (nv + bv);
    e.pass = (rv == av);
    e.reca = 4'(rv & 15);
    e.ovf  = (nv > 7) || (nv < -8);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom % 2);
    else out_ready = rdy_hold;
  end

  // Monitor
  logic       held_v = 1'b0;
  logic       held_p;
  logic [3:0] held_r;
  logic       held_o;

  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      chk("err_count", err_count, model_err);
      if (held_v && out_valid) begin
        chk("hold_pass", pass, held_p);
        chk("hold_reca", recovered_a, held_r);
        chk("hold_ovf", overflow, held_o);
      end
      held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_verdict", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pass", pass, e.pass);
          chk("recovered_a", recovered_a, e.reca);
          chk("overflow", overflow, e.ovf);
          if (!e.pass && model_err < 255) model_err++;
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held_p = pass;
        held_r = recovered_a;
        held_o = overflow;
      end
    end
  end

  // Drive one tuple; garbage in_valid pulses while busy must be ignored.
  task automatic send(input logic [3:0] ai, input logic [3:0] bi,
                      input logic si, input logic [4:0] ansi);
    int n = 0;
    while (!in_ready && n < 50) begin
      in_valid = 1'($urandom % 2);
      a   = 4'($urandom);
      b   = 4'($urandom);
      sel = 1'($urandom);
      ans = 5'($urandom);
      step();
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      a = ai; b = bi; sel = si; ans = ansi;
      in_valid = 1'b1;
      q.push_back(model(ai, bi, si, ansi));
      step();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    exp_t dummy;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pass", pass, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_reca", recovered_a, 0);
    chk("rst_err", err_count, 0);
    step();

    // a=5 b=3 add ans=8, with latency check
    send(4'd5, 4'd3, 1'b1, 5'b01000);
    @(negedge clk);
    chk("lat_calc_valid", out_valid, 0);
    chk("lat_calc_ready", in_ready, 0);
    @(negedge clk);
    chk("lat_report_valid", out_valid, 1);
    chk("d1_pass", pass, 1);
    chk("d1_reca", recovered_a, 5);
    chk("d1_ovf", overflow, 1);
    step();

    send(4'b1000, 4'd1, 1'b0, 5'b10111);
    @(negedge clk);
    @(negedge clk);
    chk("d2_pass", pass, 1);
    chk("d2_reca", recovered_a, 8);
    chk("d2_ovf", overflow, 1);
    step();

    // stalled consumer: verdict must hold for 5 cycles
    rdy_mode = 2;
    rdy_hold = 1'b0;
    send(4'd3, 4'd2, 1'b1, 5'd6);
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("d3_pass", pass, 0);
    chk("d3_reca", recovered_a, 4);
    chk("d3_ovf", overflow, 0);
    chk("d3_err_before", err_count, 0);
    rdy_hold = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("d3_err_after", err_count, 1);
    rdy_mode = 0;

    for (int i = 0; i < 260; i++) send(4'd0, 4'd0, 1'b1, 5'd1);
    step();
    step();
    @(negedge clk);
    chk("sat_err", err_count, 255);
    reset = 1'b1;
    q.delete();
    model_err = 0;
    step();
    reset = 1'b0;

    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ra, rb;
      logic rs;
      logic [4:0] rn;
      int v;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rs = 1'($urandom);
      v  = rs ? ($signed(ra) + $signed(rb)) : ($signed(ra) - $signed(rb));
      rn = ($urandom % 2) ? 5'(v) : 5'($urandom);
      send(ra, rb, rs, rn);
    end
    rdy_mode = 0;
    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    chk("drain", q.size(), 0);

    // reset while in REPORT discards the tuple
    rdy_mode = 2;
    rdy_hold = 1'b0;
    send(4'd1, 4'd1, 1'b1, 5'd7);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("r24_in_report", out_valid, 1);
    step();
    reset = 1'b1;
    dummy = q.pop_back();
    model_err = 0;
    step();
    reset = 1'b0;
    rdy_hold = 1'b1;
    @(negedge clk);
    chk("r24_out_valid", out_valid, 0);
    chk("r24_err", err_count, 0);
    chk("r24_in_ready", in_ready, 1);
    step();
    step();
    @(negedge clk);
    chk("r24_no_verdict", out_valid, 0);
    chk("r24_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
